// File: rtl/sub17post_pkg.sv
// Shared widths and result layout for the post-subtract sign/magnitude/LZC stage.
package sub17post_pkg;

    localparam int unsigned W   = 17;
    localparam int unsigned LZW = 5;

    typedef struct packed {
        logic           sign;
        logic [W-1:0]   mag;
        logic [LZW-1:0] lzc;
        logic           zero;
    } res_t;

endpackage

// File: rtl/sub17post_inc17cla.sv
// W-bit conditional incrementer: 1-bit LSB slice followed by 4-bit lookahead blocks.
module inc17cla
    import sub17post_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic         inc,
    output logic [W-1:0] sum
);

    localparam int unsigned NB = (W - 1) / 4;

    logic [NB-1:0] c;

    assign sum[0] = x[0] ^ inc;
    assign c[0]   = x[0] & inc;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int unsigned LO = 1 + 4 * k;
        logic [3:0] xb;
        logic [3:0] pre;

        assign xb  = x[LO +: 4];
        // In-block prefix propagate: bit j flips when all lower block bits are ones.
        assign pre = {&xb[2:0], &xb[1:0], xb[0], 1'b1};
        assign sum[LO +: 4] = xb ^ ({4{c[k]}} & pre);

        if (k < NB - 1) begin : g_carry
            assign c[k+1] = c[k] & (&xb);
        end
    end

endmodule

// File: rtl/sub17post.sv
// Two-stage valid/ready pipeline: raw difference -> sign, |diff|, leading-zero count, zero flag.
module sub17post
    import sub17post_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   diff,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sign,
    output logic [W-1:0]   mag,
    output logic [LZW-1:0] lzc,
    output logic           zero
);

    logic         s1_v;
    logic         s1_sign;
    logic [W-1:0] s1_x;
    logic         s2_v;
    res_t         s2_q;

    logic           s1_en;
    logic           s2_en;
    logic [W-1:0]   mag_c;
    logic [LZW-1:0] lzc_c;
    res_t           s2_d;

    assign s2_en    = !s2_v || out_ready;
    assign s1_en    = !s1_v || s2_en;
    assign in_ready = s1_en;

    // The sign bit doubles as the +1 of the two's-complement negate.
    inc17cla u_inc (
        .x   (s1_x),
        .inc (s1_sign),
        .sum (mag_c)
    );

    // Priority encoder: the highest set bit wins since it is visited last.
    always_comb begin
        lzc_c = LZW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (mag_c[i]) begin
                lzc_c = LZW'(W - 1 - i);
            end
        end
    end

    always_comb begin
        s2_d.sign = s1_sign;
        s2_d.mag  = mag_c;
        s2_d.lzc  = lzc_c;
        s2_d.zero = (mag_c == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_x    <= '0;
            s2_v    <= 1'b0;
            s2_q    <= '0;
        end else begin
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q <= s2_d;
                end
            end
            if (s1_en) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_sign <= diff[W-1];
                    s1_x    <= diff[W-1] ? ~diff : diff;
                end
            end
        end
    end

    assign out_valid = s2_v;
    assign sign      = s2_q.sign;
    assign mag       = s2_q.mag;
    assign lzc       = s2_q.lzc;
    assign zero      = s2_q.zero;

endmodule

// File: tb/tb_sub17post.sv
// Self-checking bench for sub17post: directed cases, stall/backpressure, random stream, mid-stream reset.
module tb_sub17post;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] diff;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [16:0] mag;
    logic [4:0]  lzc;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    sub17post dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .lzc       (lzc),
        .zero      (zero)
    );

    // Reference: absolute value by modular arithmetic, lzc from the bit length of the magnitude.
    function automatic logic [23:0] model(input logic [16:0] d);
        int   v;
        int   t;
        int   len;
        logic s;
        s   = d[16];
        v   = s ? (131072 - int'(d)) : int'(d);
        v   = v % 131072;
        len = 0;
        t   = v;
        while (t > 0) begin
            t = t / 2;
            len++;
        end
        return {s, 17'(v), 5'(17 - len), (v == 0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; diff = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, sign, mag, lzc, zero} !== {1'b0, 1'b1, 1'b0, 17'h0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got ov=%b ir=%b s=%b m=%h l=%0d z=%b, want ov=0 ir=1 all fields 0",
                     out_valid, in_ready, sign, mag, lzc, zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [16:0] d, input logic [23:0] want, input string name);
        out_ready = 1'b1; in_valid = 1'b1; diff = d;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, sign, mag, lzc, zero} !== {1'b1, want}) begin
            n_fail++;
            $display("FAIL %s: got ov=%b s=%b m=%h l=%0d z=%b, want ov=1 s=%b m=%h l=%0d z=%b",
                     name, out_valid, sign, mag, lzc, zero, want[23], want[22:6], want[5:1], want[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; diff = 17'h10000;
        @(negedge clk);
        diff = 17'h00000;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, sign, mag, lzc, zero} !== {1'b1, 1'b1, 17'h10000, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first: got ov=%b s=%b m=%h l=%0d z=%b, want ov=1 s=1 m=10000 l=0 z=0",
                     out_valid, sign, mag, lzc, zero);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, sign, mag, lzc, zero} !== {1'b1, 1'b0, 17'h00000, 5'd17, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: got ov=%b s=%b m=%h l=%0d z=%b, want ov=1 s=0 m=0 l=17 z=1",
                     out_valid, sign, mag, lzc, zero);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got  = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (sent < 4); diff = 17'(sent + 1);
            #1;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (sent !== 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_capacity: accepted=%0d in_ready=%b, want accepted=2 in_ready=0", sent, in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || mag !== 17'd1) begin
            n_fail++;
            $display("FAIL stall_hold: ov=%b mag=%h, want ov=1 mag=00001", out_valid, mag);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b want 1", in_ready);
        end
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (sent < 4); diff = 17'(sent + 1);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (mag !== 17'(got + 1)) begin
                    n_fail++;
                    $display("FAIL stall_order: result %0d mag=%h want %h", got, mag, 17'(got + 1));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results want 4", got);
        end
    endtask

    task automatic test_random();
        int          n_in  = 0;
        int          n_out = 0;
        logic [23:0] got;
        logic [23:0] want;
        exp_q.delete();
        for (int cyc = 0; cyc < 10040; cyc++) begin
            if (cyc < 10000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                diff      = 17'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                got = {sign, mag, lzc, zero};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_extra: unexpected result %h at cycle %0d", got, cyc);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL random_result: cycle %0d got %h want %h", cyc, got, want);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(diff));
                n_in++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_in !== n_out || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_count: in=%0d out=%0d pending=%0d", n_in, n_out, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; diff = 17'(100 + c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL reset_stale: %0d stale results, want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single(17'h00005, {1'b0, 17'h00005, 5'd14, 1'b0}, "pos5");
        test_single(17'h1FFFF, {1'b1, 17'h00001, 5'd16, 1'b0}, "neg1");
        test_single(17'h00000, model(17'h00000), "zero");
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
